btn_debounce: RTL and testbench

- Multi-channel push-button conditioner.
- Synchronises raw asynchronous button/switch inputs into the CLK domain and debounces each channel with a per-channel counter FSM.
- Produces a clean level plus single-cycle PRESS/RELEASE strobes.
- Sits directly upstream of the team's enable-gated D flip-flop/register stages: PRESS drives their EN, LEVEL their D.

---
 rtl/btn_debounce_if.sv | 13 +
 rtl/btn_debounce.sv | 149 ++++++++++++++
 tb/tb_btn_debounce.sv | 137 +++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// Button conditioner bundle: raw inputs in, debounced level and strobes out.
// The debouncer takes the master modport; consumers/stimulus take slave.
interface btn_debounce_if #(
   parameter int N = 4
);
   logic [N-1:0] BTN_IN;
   logic [N-1:0] LEVEL;
   logic [N-1:0] PRESS;
   logic [N-1:0] RELEASE;

   modport master (input BTN_IN, output LEVEL, PRESS, RELEASE);
   modport slave  (output BTN_IN, input LEVEL, PRESS, RELEASE);
endinterface

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: 2-flop synchroniser plus per-channel
// counter FSM; optional auto-repeat of PRESS under `BTN_DEBOUNCE_AUTOREPEAT_EN`.
module btn_debounce #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input logic          CLK,
   input logic          RST,
   btn_debounce_if.master bus
);

   if (N < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("btn_debounce: illegal parameter value");
   end

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CHK_HI, HIGH, CHK_LO} state_t;

   logic [N-1:0]  s1, s2;
   state_t        state_q [N];
   state_t        state_d [N];
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [N-1:0]  level_q, level_d;
   logic [N-1:0]  press_q, press_d;
   logic [N-1:0]  rel_q, rel_d;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rcnt_q [N];
   logic [RW-1:0] rcnt_d [N];
   logic [N-1:0]  rfirst_q, rfirst_d;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1      <= '0;
         s2      <= '0;
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         rfirst_q <= '1;
         for (int i = 0; i < N; i++) rcnt_q[i] <= '0;
`endif
      end else begin
         s1      <= bus.BTN_IN;
         s2      <= s1;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         rfirst_q <= rfirst_d;
         for (int i = 0; i < N; i++) rcnt_q[i] <= rcnt_d[i];
`endif
      end
   end

   // Counter is cleared on every state change, so it never exceeds CNT_LAST.
   always_comb begin
      level_d = level_q;
      press_d = '0;
      rel_d   = '0;
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            IDLE: begin
               if (s2[i]) begin
                  state_d[i] = CHK_HI;
                  cnt_d[i]   = '0;
               end
            end
            CHK_HI: begin
               if (!s2[i]) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = HIGH;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b1;
                  press_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            HIGH: begin
               if (!s2[i]) begin
                  state_d[i] = CHK_LO;
                  cnt_d[i]   = '0;
               end
            end
            CHK_LO: begin
               if (s2[i]) begin
                  state_d[i] = HIGH;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b0;
                  rel_d[i]   = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
         // Repeat timer only advances while staying in HIGH; any exit restarts the delay.
         rcnt_d[i]   = '0;
         rfirst_d[i] = 1'b1;
         if (state_q[i] == HIGH && s2[i]) begin
            rfirst_d[i] = rfirst_q[i];
            if (rcnt_q[i] == (rfirst_q[i] ? RD_LAST : RP_LAST)) begin
               press_d[i]  = 1'b1;
               rfirst_d[i] = 1'b0;
            end else begin
               rcnt_d[i] = rcnt_q[i] + 1'b1;
            end
         end
`endif
      end
   end

   assign bus.LEVEL   = level_q;
   assign bus.PRESS   = press_q;
   assign bus.RELEASE = rel_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (N=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4).
module tb_btn_debounce;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   btn_debounce_if #(.N(2)) bus ();

   btn_debounce #(
      .N(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   typedef struct {
      logic       r;
      logic [1:0] btn;
      logic [1:0] lvl;
      logic [1:0] prs;
      logic [1:0] rel;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [1:0] btn, input logic [1:0] lvl,
                      input logic [1:0] prs, input logic [1:0] rel);
      vec_t v;
      v.r = r; v.btn = btn; v.lvl = lvl; v.prs = prs; v.rel = rel;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %b expected %b at %0t", nm, idx, act, exp, $time);
      end
   endtask

   // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
   task automatic apply(input vec_t v, input int idx);
      rst        = v.r;
      bus.BTN_IN = v.btn;
      @(posedge clk);
      @(negedge clk);
      chk("LEVEL",   idx, bus.LEVEL,   v.lvl);
      chk("PRESS",   idx, bus.PRESS,   v.prs);
      chk("RELEASE", idx, bus.RELEASE, v.rel);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      rst        = 1'b1;
      bus.BTN_IN = 2'b00;
      @(negedge clk);
      @(negedge clk);
      chk("rst_LEVEL",   0, bus.LEVEL,   2'b00);
      chk("rst_PRESS",   0, bus.PRESS,   2'b00);
      chk("rst_RELEASE", 0, bus.RELEASE, 2'b00);

      // Clean press on channel 0, held 20 cycles (auto-repeat at 15 and 19 when enabled).
      for (int i = 1; i <= 20; i++)
         add(0, 2'b01, (i >= 7) ? 2'b01 : 2'b00,
             (i == 7 || (AR && (i == 15 || i == 19))) ? 2'b01 : 2'b00, 2'b00);
      // Clean release.
      for (int i = 1; i <= 10; i++)
         add(0, 2'b00, (i < 7) ? 2'b01 : 2'b00, 2'b00, (i == 7) ? 2'b01 : 2'b00);
      // Press again, then a one-cycle high glitch while checking the release.
      for (int i = 1; i <= 10; i++)
         add(0, 2'b01, (i >= 7) ? 2'b01 : 2'b00, (i == 7) ? 2'b01 : 2'b00, 2'b00);
      for (int i = 1; i <= 3; i++) add(0, 2'b00, 2'b01, 2'b00, 2'b00);
      add(0, 2'b01, 2'b01, 2'b00, 2'b00);
      for (int i = 1; i <= 8; i++)
         add(0, 2'b00, (i < 7) ? 2'b01 : 2'b00, 2'b00, (i == 7) ? 2'b01 : 2'b00);
      // Bounce 1,1,0,0,1,1,0,0 then stable high.
      for (int i = 0; i < 8; i++) add(0, (i % 4 < 2) ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00);
      for (int i = 1; i <= 10; i++)
         add(0, 2'b01, (i >= 7) ? 2'b01 : 2'b00, (i == 7) ? 2'b01 : 2'b00, 2'b00);
      for (int i = 1; i <= 10; i++)
         add(0, 2'b00, (i < 7) ? 2'b01 : 2'b00, 2'b00, (i == 7) ? 2'b01 : 2'b00);
      // Both channels together.
      for (int i = 1; i <= 10; i++)
         add(0, 2'b11, (i >= 7) ? 2'b11 : 2'b00, (i == 7) ? 2'b11 : 2'b00, 2'b00);
      for (int i = 1; i <= 10; i++)
         add(0, 2'b00, (i < 7) ? 2'b11 : 2'b00, 2'b00, (i == 7) ? 2'b11 : 2'b00);

      foreach (tbl[k]) apply(tbl[k], k);

      // Reset in the middle of a check with channel 1 already accepted.
      for (int i = 1; i <= 8; i++) begin
         v.r = 0; v.btn = 2'b10;
         v.lvl = (i >= 7) ? 2'b10 : 2'b00; v.prs = (i == 7) ? 2'b10 : 2'b00; v.rel = 2'b00;
         apply(v, 1000 + i);
      end
      for (int i = 1; i <= 3; i++) begin
         v.r = 0; v.btn = 2'b11; v.lvl = 2'b10; v.prs = 2'b00; v.rel = 2'b00;
         apply(v, 1010 + i);
      end
      rst = 1'b1;
      #1;
      chk("async_LEVEL",   1020, bus.LEVEL,   2'b00);
      chk("async_PRESS",   1020, bus.PRESS,   2'b00);
      chk("async_RELEASE", 1020, bus.RELEASE, 2'b00);
      @(negedge clk);
      for (int i = 1; i <= 2; i++) begin
         v.r = 1; v.btn = 2'b11; v.lvl = 2'b00; v.prs = 2'b00; v.rel = 2'b00;
         apply(v, 1030 + i);
      end
      for (int i = 1; i <= 9; i++) begin
         v.r = 0; v.btn = 2'b11;
         v.lvl = (i >= 7) ? 2'b11 : 2'b00; v.prs = (i == 7) ? 2'b11 : 2'b00; v.rel = 2'b00;
         apply(v, 1040 + i);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
